sys1_audio_post: RTL and testbench



---
 rtl/sys1_audio_pkg.sv | 20 ++
 rtl/sys1_audio_post_if.sv | 14 +
 rtl/sys1_audio_tickgen.sv | 28 ++
 rtl/sys1_audio_post.sv | 116 +++++++++++
 tb/tb_sys1_audio_post.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/sys1_audio_pkg.sv
// rtl/sys1_audio_pkg.sv - shared constants, sample type and saturation helper for sys1_audio_post
package sys1_audio_pkg;

  localparam logic [12:0] PHASE_INC = 13'd6;
  localparam logic [12:0] PHASE_MOD = 13'd5000;
  localparam logic [15:0] CENTER    = 16'h4000;

  typedef logic signed [15:0] sample_t;

  function automatic sample_t sat16(input logic signed [17:0] v);
    if (v > 18'sd32767) begin
      return 16'sh7fff;
    end else if (v < -18'sd32768) begin
      return 16'sh8000;
    end else begin
      return sample_t'(v[15:0]);
    end
  endfunction

endpackage

// File: rtl/sys1_audio_post_if.sv
// rtl/sys1_audio_post_if.sv - PSG mix in, 48 kHz PCM out bundle for sys1_audio_post
interface sys1_audio_post_if;
  import sys1_audio_pkg::*;

  logic [15:0] snd_in;
  logic        mute;
  sample_t     pcm_out;
  logic        pcm_valid;
  logic        tick48;

  modport master (output snd_in, mute, input pcm_out, pcm_valid, tick48);
  modport slave  (input snd_in, mute, output pcm_out, pcm_valid, tick48);

endinterface

// File: rtl/sys1_audio_tickgen.sv
// rtl/sys1_audio_tickgen.sv - 48 kHz tick from 40 MHz via a 6/5000 phase accumulator
module sys1_audio_tickgen
  import sys1_audio_pkg::*;
(
  input  logic clk40M,
  input  logic reset,
  output logic tick_now,
  output logic tick48
);

  logic [12:0] phase;
  logic [12:0] phase_nxt;

  // tick_now is the wrap decision for this edge; tick48 is its registered copy
  assign phase_nxt = phase + PHASE_INC;
  assign tick_now  = (phase_nxt >= PHASE_MOD);

  always_ff @(posedge clk40M or posedge reset) begin
    if (reset) begin
      phase  <= '0;
      tick48 <= 1'b0;
    end else begin
      phase  <= tick_now ? (phase_nxt - PHASE_MOD) : phase_nxt;
      tick48 <= tick_now;
    end
  end

endmodule

// File: rtl/sys1_audio_post.sv
// rtl/sys1_audio_post.sv - decimate, re-center, optional DC block (SYS1_AUDIO_DCBLOCK_EN), low-pass PSG mix to 48 kHz PCM
module sys1_audio_post
  import sys1_audio_pkg::*;
#(
  parameter int WIN_LOG2 = 9,
  parameter int LP_SHIFT = 2
`ifdef SYS1_AUDIO_DCBLOCK_EN
  ,
  parameter int DC_SHIFT = 8
`endif
) (
  input  logic             clk40M,
  input  logic             reset,
  sys1_audio_post_if.slave aud
);

  localparam int SUM_W = 16 + WIN_LOG2;
  localparam int CNT_W = WIN_LOG2 + 1;
  localparam logic [CNT_W-1:0] WIN_LEN = {1'b1, {WIN_LOG2{1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{WIN_LOG2{1'b0}}, 1'b1};

  logic               tick_now;
  logic               tick48;
  logic [SUM_W-1:0]   sum;
  logic [CNT_W-1:0]   win_cnt;
  logic [15:0]        avg;
  sample_t            x;
  sample_t            y;
  sample_t            l;
  sample_t            pcm_q;
  logic               v1;
  logic               v2;
  logic               pcm_v;
  logic signed [17:0] lp_diff;
  logic signed [17:0] lp_sum;

  sys1_audio_tickgen u_tickgen (
    .clk40M   (clk40M),
    .reset    (reset),
    .tick_now (tick_now),
    .tick48   (tick48)
  );

  // The tick-edge sample opens the next window; samples past WIN_LEN are dropped
  always_ff @(posedge clk40M or posedge reset) begin
    if (reset) begin
      sum     <= '0;
      win_cnt <= '0;
      avg     <= '0;
    end else if (tick_now) begin
      avg     <= sum[SUM_W-1:WIN_LOG2];
      sum     <= {{WIN_LOG2{1'b0}}, aud.snd_in};
      win_cnt <= CNT_ONE;
    end else if (win_cnt < WIN_LEN) begin
      sum     <= sum + {{WIN_LOG2{1'b0}}, aud.snd_in};
      win_cnt <= win_cnt + CNT_ONE;
    end
  end

  assign x = sample_t'(avg - CENTER);

  // tick48 doubles as "avg was just latched", enabling the T+1 stage
`ifdef SYS1_AUDIO_DCBLOCK_EN
  sample_t            x_prev;
  logic signed [17:0] dc_sum;

  assign dc_sum = 18'(x) - 18'(x_prev) + 18'(y) - 18'(y >>> DC_SHIFT);

  always_ff @(posedge clk40M or posedge reset) begin
    if (reset) begin
      x_prev <= '0;
      y      <= '0;
    end else if (tick48) begin
      x_prev <= x;
      y      <= sat16(dc_sum);
    end
  end
`else
  always_ff @(posedge clk40M or posedge reset) begin
    if (reset) begin
      y <= '0;
    end else if (tick48) begin
      y <= x;
    end
  end
`endif

  // One extra bit beyond 17 keeps y - l exact even when both sit at opposite rails
  assign lp_diff = 18'(y) - 18'(l);
  assign lp_sum  = 18'(l) + (lp_diff >>> LP_SHIFT);

  always_ff @(posedge clk40M or posedge reset) begin
    if (reset) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      pcm_v <= 1'b0;
      l     <= '0;
      pcm_q <= '0;
    end else begin
      v1    <= tick48;
      v2    <= v1;
      pcm_v <= v2;
      if (v1) begin
        l <= sat16(lp_sum);
      end
      if (v2) begin
        pcm_q <= aud.mute ? '0 : l;
      end
    end
  end

  assign aud.pcm_out   = pcm_q;
  assign aud.pcm_valid = pcm_v;
  assign aud.tick48    = tick48;

endmodule

// File: tb/tb_sys1_audio_post.sv
// tb/tb_sys1_audio_post.sv - directed scoreboard bench for sys1_audio_post
`timescale 1ns/100ps
module tb_sys1_audio_post;
  import sys1_audio_pkg::*;

  typedef struct {
    int due;
    int val;
  } exp_t;

  logic clk40M = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  sys1_audio_post_if aif ();

  sys1_audio_post dut (
    .clk40M (clk40M),
    .reset  (reset),
    .aud    (aif.slave)
  );

  always #12.5 clk40M = ~clk40M;

  exp_t sb[$];
  int   edge_n;
  int   m_sum, m_cnt, m_xp, m_yp, m_lp;
  bit   m_tick;
  int   tick_cnt, first_tick, last_tick;
  int   n_valid, last_pcm;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic model_reset();
    edge_n     = 0;
    m_sum      = 0;
    m_cnt      = 0;
    m_xp       = 0;
    m_yp       = 0;
    m_lp       = 0;
    m_tick     = 1'b0;
    first_tick = 0;
    last_tick  = 0;
    sb.delete();
  endtask

  // Expected sample for a tick at edge_n, due on the output three edges later
  task automatic model_sample();
    int avg, x, y;
    avg = m_sum / 512;
    x   = avg - 16384;
`ifdef SYS1_AUDIO_DCBLOCK_EN
    y    = sat(x - m_xp + m_yp - (m_yp >>> 8));
    m_xp = x;
`else
    y = x;
`endif
    m_yp = y;
    m_lp = sat(m_lp + ((y - m_lp) >>> 2));
    sb.push_back('{due: edge_n + 3, val: m_lp});
  endtask

  task automatic observe();
    exp_t e;
    if (aif.tick48 || m_tick) begin
      chk("tick48", aif.tick48, m_tick);
    end
    if (aif.tick48) begin
      tick_cnt++;
      if (first_tick == 0) first_tick = edge_n;
      if (last_tick > 0) begin
        chk("tick_spacing", ((edge_n - last_tick) == 833) || ((edge_n - last_tick) == 834), 1);
      end
      last_tick = edge_n;
    end
    if (sb.size() > 0 && sb[0].due == edge_n) begin
      e = sb.pop_front();
      chk("pcm_valid", aif.pcm_valid, 1);
      chk("pcm_out", aif.pcm_out, aif.mute ? 0 : e.val);
      n_valid++;
      last_pcm = aif.pcm_out;
    end else if (aif.pcm_valid) begin
      chk("pcm_valid_spurious", aif.pcm_valid, 0);
    end
  endtask

  // Inputs change on negedges, so both model and DUT see them stable at the posedge
  task automatic cyc();
    @(posedge clk40M);
    m_tick = 1'b0;
    if (reset) begin
      model_reset();
    end else begin
      edge_n++;
      m_tick = ((edge_n * 6) / 5000) != (((edge_n - 1) * 6) / 5000);
      if (m_tick) begin
        model_sample();
        m_sum = aif.snd_in;
        m_cnt = 1;
      end else if (m_cnt < 512) begin
        m_sum += aif.snd_in;
        m_cnt++;
      end
    end
    @(negedge clk40M);
    observe();
  endtask

  initial begin
    int target, prev_pcm, peak, base;
    reset      = 1'b1;
    aif.snd_in = 16'h4000;
    aif.mute   = 1'b0;
    model_reset();
    tick_cnt = 0;
    n_valid  = 0;
    last_pcm = 0;
    repeat (3) @(negedge clk40M);
    chk("rst_pcm_out", aif.pcm_out, 0);
    chk("rst_pcm_valid", aif.pcm_valid, 0);
    chk("rst_tick48", aif.tick48, 0);
    reset = 1'b0;

    // Tick rate with a centered constant input
    repeat (50000) cyc();
    chk("tick_count", tick_cnt, 60);
    chk("first_tick", first_tick, 834);
    chk("centered_valids", n_valid, 59);
    chk("centered_last", last_pcm, 0);

    // Full-scale step
    aif.snd_in = 16'd32640;
    target   = n_valid + 41;
    prev_pcm = last_pcm;
    peak     = last_pcm;
    for (int i = 0; i < 41 * 834 + 900 && n_valid < target; i++) begin
      base = n_valid;
      cyc();
      if (n_valid != base) begin
`ifndef SYS1_AUDIO_DCBLOCK_EN
        chk("step_monotonic", last_pcm >= prev_pcm, 1);
`endif
        if (last_pcm > peak) peak = last_pcm;
        prev_pcm = last_pcm;
      end
    end
    chk("step_samples", n_valid, target);
`ifdef SYS1_AUDIO_DCBLOCK_EN
    chk("dc_peak_decay", (peak > 0) && (last_pcm < peak), 1);
`else
    // Floor rounding stalls the low-pass up to 3 LSB below its target
    chk("dc_off_settle", (last_pcm >= 16253) && (last_pcm <= 16256), 1);
`endif

    // Mute keeps strobes, zeroes data; unmute shows the live filter value
    aif.mute   = 1'b1;
    aif.snd_in = 16'd0;
    target = n_valid + 3;
    for (int i = 0; i < 3 * 834 + 900 && n_valid < target; i++) begin
      base = n_valid;
      cyc();
      if (n_valid != base) chk("mute_zero", last_pcm, 0);
    end
    chk("mute_samples", n_valid, target);
    aif.mute = 1'b0;
    target = n_valid + 1;
    for (int i = 0; i < 900 && n_valid < target; i++) cyc();
    chk("unmute_samples", n_valid, target);
    chk("unmute_nonzero", last_pcm != 0, 1);

    // Reset two cycles after a tick discards the in-flight sample
    for (int i = 0; i < 900 && !aif.tick48; i++) cyc();
    chk("pre_reset_tick", aif.tick48, 1);
    cyc();
    cyc();
    reset = 1'b1;
    model_reset();
    cyc();
    chk("midrst_pcm_valid", aif.pcm_valid, 0);
    chk("midrst_pcm_out", aif.pcm_out, 0);
    chk("midrst_tick48", aif.tick48, 0);
    cyc();
    reset = 1'b0;
    base  = n_valid;
    for (int i = 0; i < 900 && !aif.tick48; i++) cyc();
    chk("post_reset_tick48", aif.tick48, 1);
    chk("post_reset_tick_at", edge_n, 834);
    repeat (4) cyc();
    chk("post_reset_sample", n_valid, base + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
